// File: rtl/avr_fetch_unit.sv
// Instruction fetch unit for an AVR-style core: reads 16-bit words from program ROM and hands
// one- or two-word instruction bundles to the decoder. Optional skip support is enabled by the macro AVR_FETCH_SKIP_EN.
module avr_fetch_unit (
    input  logic        clk,
    input  logic        rst_n,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        redirect,
    input  logic [13:0] redirect_pc,
    input  logic        skip,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word,
    output logic [15:0] instr_op2,
    output logic        instr_two_word,
    output logic [13:0] instr_pc,
    output logic [13:0] ret_pc
);

    typedef enum logic {
        FETCH  = 1'b0,
        FETCH2 = 1'b1
    } state_t;

    state_t      state;
    logic [13:0] pc;
    logic [13:0] held_pc;
    logic [15:0] held_word;
    logic        out_free;
    logic        consumed;
    logic        rom_two_word;
    logic        load_bundle;
    logic        skip_now;

    assign rom_addr = pc;
    assign out_free = !instr_valid || instr_ready;
    assign consumed = instr_valid && instr_ready;

    // call, jmp, lds and sts carry a second word holding an address
    assign rom_two_word =
        ((rom_data[15:9] == 7'b1001010) && (rom_data[3:1] == 3'b111)) ||
        ((rom_data[15:9] == 7'b1001010) && (rom_data[3:1] == 3'b110)) ||
        ((rom_data[15:9] == 7'b1001000) && (rom_data[3:0] == 4'b0000)) ||
        ((rom_data[15:9] == 7'b1001001) && (rom_data[3:0] == 4'b0000));

    assign load_bundle = !redirect && out_free && ((state == FETCH2) || !rom_two_word);

`ifdef AVR_FETCH_SKIP_EN
    logic skip_pending;

    // A skip taken while the very next instruction loads must suppress that load immediately
    assign skip_now = skip_pending || (consumed && skip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_pending <= 1'b0;
        end else if (redirect || load_bundle) begin
            skip_pending <= 1'b0;
        end else begin
            skip_pending <= skip_now;
        end
    end
`else
    logic unused_skip;

    assign unused_skip = skip ^ consumed;
    assign skip_now    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            pc             <= 14'h0000;
            held_pc        <= 14'h0000;
            held_word      <= 16'h0000;
            instr_valid    <= 1'b0;
            instr_word     <= 16'h0000;
            instr_op2      <= 16'h0000;
            instr_two_word <= 1'b0;
            instr_pc       <= 14'h0000;
            ret_pc         <= 14'h0000;
        end else if (redirect) begin
            state       <= FETCH;
            pc          <= redirect_pc;
            held_pc     <= 14'h0000;
            held_word   <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (out_free) begin
            pc <= pc + 14'd1;
            case (state)
                FETCH: begin
                    if (rom_two_word) begin
                        held_word   <= rom_data;
                        held_pc     <= pc;
                        instr_valid <= 1'b0;
                        state       <= FETCH2;
                    end else begin
                        instr_word     <= rom_data;
                        instr_op2      <= 16'h0000;
                        instr_two_word <= 1'b0;
                        instr_pc       <= pc;
                        ret_pc         <= pc + 14'd1;
                        instr_valid    <= !skip_now;
                    end
                end
                FETCH2: begin
                    instr_word     <= held_word;
                    instr_op2      <= rom_data;
                    instr_two_word <= 1'b1;
                    instr_pc       <= held_pc;
                    ret_pc         <= held_pc + 14'd2;
                    instr_valid    <= !skip_now;
                    state          <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/avr_fetch_unit.md
AVR_FETCH_UNIT -- requirements
Module: avr_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port rom_addr, output, 14: word address to program ROM, combinationally equal to internal pc.
REQ-004 SHALL have port rom_data, input, 16: ROM word, combinational (same-cycle) read of rom_addr.
REQ-005 SHALL have port redirect, input, 1: load pc from redirect_pc, flush fetch.
REQ-006 SHALL have port redirect_pc, input, 14: redirect target word address.
REQ-007 SHALL have port skip, input, 1: discard next delivered instruction (see Configuration).
REQ-008 SHALL have port instr_valid, output, 1: output bundle holds a complete instruction.
REQ-009 SHALL have port instr_ready, input, 1: decoder accepts the bundle this cycle.
REQ-010 SHALL have port instr_word, output, 16: first instruction word.
REQ-011 SHALL have port instr_op2, output, 16: second word of two-word instruction, else 0x0000.
REQ-012 SHALL have port instr_two_word, output, 1: bundle is a two-word instruction.
REQ-013 SHALL have port instr_pc, output, 14: address of instr_word.
REQ-014 SHALL have port ret_pc, output, 14: address following the bundle (instr_pc+1 or +2, mod 2^14).

Function
REQ-015 SHALL classify a word as two-word iff it matches call 1001010xxxxx111x, jmp 1001010xxxxx110x, lds 1001000xxxxx0000, or sts 1001001xxxxx0000.
REQ-016 SHALL implement states FETCH (first word) and FETCH2 (second word); out_free = !instr_valid | instr_ready.
REQ-017 SHALL, in FETCH with out_free and a one-word rom_data: load bundle (op2=0, two_word=0, instr_pc=pc), set instr_valid, pc<=pc+1, stay FETCH.
REQ-018 SHALL, in FETCH with out_free and a two-word rom_data: hold word and its pc internally, clear instr_valid if consumed, pc<=pc+1, go FETCH2.
REQ-019 SHALL, in FETCH2 with out_free: load bundle {held word, rom_data, two_word=1}, set instr_valid, pc<=pc+1, go FETCH.
REQ-020 SHALL, when !out_free: hold pc, state, held word and all outputs unchanged.
REQ-021 SHALL clear instr_valid when the bundle is consumed and no new bundle is loaded that cycle.
REQ-022 SHALL sustain one instruction per cycle for one-word code and one per two cycles for two-word code with instr_ready held high.
REQ-023 SHALL wrap pc from 0x3FFF to 0x0000, including between the two words of a two-word instruction.
REQ-024 SHALL give redirect priority over all other events: pc<=redirect_pc, instr_valid<=0, state<=FETCH, held word and skip_pending discarded; a bundle handshaken in that same cycle counts as consumed.

Reset
REQ-025 SHALL, while rst_n=0: pc=0x0000, state=FETCH, instr_valid=0, instr_word=0x0000, instr_op2=0x0000, instr_two_word=0, instr_pc=0x0000, ret_pc=0x0000, skip_pending=0.
REQ-026 SHALL take effect immediately on rst_n falling, including mid-FETCH2; first bundle (address 0) is valid after the first rising clk edge following rst_n release.

Configuration
REQ-027 SHALL support macro AVR_FETCH_SKIP_EN.
REQ-028 SHALL, with AVR_FETCH_SKIP_EN defined: skip sampled with instr_valid&instr_ready sets skip_pending; the next complete instruction (both words if two-word) is fetched but not made valid; skip_pending then clears.
REQ-029 SHALL, without AVR_FETCH_SKIP_EN: ignore skip, no skip_pending register.

Verification
REQ-030 SHALL cover: ROM[0]=0x0000, ROM[1]=0x0C01, ready=1, release reset -> edge 1 valid word 0x0000 pc 0 ret 1; edge 2 word 0x0C01 pc 1.
REQ-031 SHALL cover: ROM[2]=0x940E, ROM[3]=0x0040 -> one bubble, then word 0x940E, op2 0x0040, two_word=1, pc 2, ret_pc 4.
REQ-032 SHALL cover: ready=0 for 3 cycles with valid bundle at pc 5 -> outputs stable, rom_addr stays 6; ready=1 -> pc 6 bundle next edge.
REQ-033 SHALL cover: redirect to 0x3FFF, ROM[0x3FFF]=0x940C, ROM[0]=0x0123 -> bundle word 0x940C op2 0x0123 pc 0x3FFF ret_pc 0x0001.
REQ-034 SHALL cover (AVR_FETCH_SKIP_EN): skip with bundle pc 4, ROM[5]=0x940C two-word -> next valid bundle pc 7; without macro -> pc 5.
REQ-035 SHALL cover: rst_n low mid-FETCH2 -> instr_valid=0 and rom_addr=0x0000 without a clock edge.
